// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_seq_pkg : states and default timing for the PLL reset sequencer  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_RST       = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_EN_CLK    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } seq_state_e;

   // Defaults assume the 50 MHz reference clock.
   localparam int C_RST_CYCLES    = 100;
   localparam int C_LOCK_STABLE   = 1024;
   localparam int C_LOCK_TIMEOUT  = 500000;
   localparam int C_EN_GAP        = 16;
   localparam int C_RELEASE_DELAY = 256;
   localparam int C_RETRY_W       = 4;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_reset_sequencer_if : PLL control, DDR reset and status bundle    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pll_reset_sequencer_if
   import pll_seq_pkg::*;
#(
   parameter int RETRY_W = C_RETRY_W
);
   logic               pll_lock;
   logic               soft_rst;
   logic               err_clr;
   logic               pll_reset;
   logic               pll_enclk0;
   logic               pll_enclk2;
   logic               ddr_rst_n;
   logic               init_ready;
   logic               lock_err;
   logic [RETRY_W-1:0] retry_cnt;

   modport master (
      input  pll_lock, soft_rst, err_clr,
      output pll_reset, pll_enclk0, pll_enclk2, ddr_rst_n, init_ready, lock_err, retry_cnt
   );

   modport slave (
      output pll_lock, soft_rst, err_clr,
      input  pll_reset, pll_enclk0, pll_enclk2, ddr_rst_n, init_ready, lock_err, retry_cnt
   );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : generic 1-bit two-flop synchronizer, async low reset      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_reset_sequencer : PLL reset / lock qualification / DDR release   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = C_RST_CYCLES,
   parameter int LOCK_STABLE   = C_LOCK_STABLE,
   parameter int LOCK_TIMEOUT  = C_LOCK_TIMEOUT,
   parameter int EN_GAP        = C_EN_GAP,
   parameter int RELEASE_DELAY = C_RELEASE_DELAY,
   parameter int RETRY_W       = C_RETRY_W
)(
   input  logic                  clk,
   input  logic                  rst_n,
   pll_reset_sequencer_if.master bus
);
   localparam int CNT_MAX = max_of(max_of(max_of(RST_CYCLES, LOCK_STABLE),
                                          max_of(EN_GAP, RELEASE_DELAY)), LOCK_TIMEOUT);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]   C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0]   C_TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   C_GAP_LAST    = CNT_W'(EN_GAP - 1);
   localparam logic [CNT_W-1:0]   C_REL_LAST    = CNT_W'(RELEASE_DELAY - 1);
   localparam logic [RETRY_W-1:0] C_RETRY_MAX   = '1;

   logic               rst_s;
   logic               lock_s;
   logic               lock_fault;
   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   tmo_q, tmo_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               err_q, err_d;
   logic               pll_reset_q, pll_reset_d;
   logic               en0_q, en0_d;
   logic               en2_q, en2_d;
   logic               ddr_rst_n_q, ddr_rst_n_d;
   logic               ready_q, ready_d;

   sync_2ff u_rst_sync  (.clk(clk), .rst_n(rst_n), .d_i(1'b1),         .q_o(rst_s));
   sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d_i(bus.pll_lock), .q_o(lock_s));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      tmo_d      = '0;
      lock_fault = 1'b0;
      case (state_q)
         ST_RST: begin
            if (!rst_s || bus.soft_rst) cnt_d = '0;
            else if (cnt_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock qualification is checked before timeout so a tie favours lock.
            tmo_d = tmo_q + 1'b1;
            if (bus.soft_rst) begin
               state_d = ST_RST;
            end else if (lock_s && (cnt_q == C_STABLE_LAST)) begin
               state_d = ST_EN_CLK;
            end else if (tmo_q == C_TMO_LAST) begin
               state_d    = ST_RST;
               lock_fault = 1'b1;
            end else if (!lock_s) begin
               cnt_d = '0;
            end
         end
         ST_EN_CLK, ST_RELEASE: begin
            if (!lock_s) begin
               state_d    = ST_RST;
               lock_fault = 1'b1;
            end else if (bus.soft_rst) begin
               state_d = ST_RST;
            end else if ((state_q == ST_EN_CLK) && (cnt_q == C_GAP_LAST)) begin
               state_d = ST_RELEASE;
            end else if ((state_q == ST_RELEASE) && (cnt_q == C_REL_LAST)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d    = ST_RST;
               lock_fault = 1'b1;
            end else if (bus.soft_rst) begin
               state_d = ST_RST;
            end
         end
         default: state_d = ST_RST;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
         tmo_d = '0;
      end

      // Outputs decode the next state so they switch on the same edge as the FSM.
      pll_reset_d = (state_d == ST_RST);
      en2_d       = state_d inside {ST_EN_CLK, ST_RELEASE, ST_RUN};
      en0_d       = state_d inside {ST_RELEASE, ST_RUN};
      ddr_rst_n_d = (state_d == ST_RUN);
      ready_d     = (state_d == ST_RUN);
      retry_d     = (lock_fault && (retry_q != C_RETRY_MAX)) ? retry_q + 1'b1 : retry_q;
      err_d       = lock_fault | (err_q & ~bus.err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RST;
         cnt_q       <= '0;
         tmo_q       <= '0;
         retry_q     <= '0;
         err_q       <= 1'b0;
         pll_reset_q <= 1'b1;
         en0_q       <= 1'b0;
         en2_q       <= 1'b0;
         ddr_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         err_q       <= err_d;
         pll_reset_q <= pll_reset_d;
         en0_q       <= en0_d;
         en2_q       <= en2_d;
         ddr_rst_n_q <= ddr_rst_n_d;
         ready_q     <= ready_d;
      end
   end

   assign bus.pll_reset  = pll_reset_q;
   assign bus.pll_enclk0 = en0_q;
   assign bus.pll_enclk2 = en2_q;
   assign bus.ddr_rst_n  = ddr_rst_n_q;
   assign bus.init_ready = ready_q;
   assign bus.lock_err   = err_q;
   assign bus.retry_cnt  = retry_q;
endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_reset_sequencer : directed self-checking bench                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pll_reset_sequencer;
   localparam int RW = 4;

   logic clk;
   logic rst_n;
   int   n_vec      = 0;
   int   n_err      = 0;
   int   order_viol = 0;

   pll_reset_sequencer_if #(.RETRY_W(RW)) bus ();

   pll_reset_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (50),
      .EN_GAP       (2),
      .RELEASE_DELAY(4),
      .RETRY_W      (RW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.pll_enclk0 === 1'b1 && bus.pll_enclk2 !== 1'b1) order_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         0:       return bus.pll_reset;
         1:       return bus.init_ready;
         default: return (bus.retry_cnt == RW'(15));
      endcase
   endfunction

   // Counts edges until the probed signal reaches lvl; a blown budget returns budget.
   task automatic wait_lvl(input int sel, input logic lvl, input int budget, output int n);
      n = 0;
      while (probe(sel) !== lvl && n < budget) begin
         tick(1);
         n++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_reset"}, bus.pll_reset, 1);
      chk({tag, "_enclk0"}, bus.pll_enclk0, 0);
      chk({tag, "_enclk2"}, bus.pll_enclk2, 0);
      chk({tag, "_ddr_rst_n"}, bus.ddr_rst_n, 0);
      chk({tag, "_init_ready"}, bus.init_ready, 0);
      chk({tag, "_lock_err"}, bus.lock_err, 0);
      chk({tag, "_retry"}, bus.retry_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  n;
      logic seen_en2;
      rst_n        = 1'b0;
      bus.pll_lock = 1'b0;
      bus.soft_rst = 1'b0;
      bus.err_clr  = 1'b0;
      tick(2);
      chk_reset_vals("por");

      // Nominal bring-up: 2 reset-sync edges + 4 RST cycles, then lock qualification.
      rst_n = 1'b1;
      wait_lvl(0, 1'b0, 20, n);
      chk("nom_rst_width", n, 6);
      tick(4);
      bus.pll_lock = 1'b1;
      tick(9);  chk("nom_en2_early", bus.pll_enclk2, 0);
      tick(1);  chk("nom_en2", bus.pll_enclk2, 1);
                chk("nom_en0_pre", bus.pll_enclk0, 0);
      tick(1);  chk("nom_en0_gap", bus.pll_enclk0, 0);
      tick(1);  chk("nom_en0", bus.pll_enclk0, 1);
                chk("nom_ddr_pre", bus.ddr_rst_n, 0);
      tick(3);  chk("nom_ready_early", bus.init_ready, 0);
      tick(1);  chk("nom_ddr", bus.ddr_rst_n, 1);
                chk("nom_ready", bus.init_ready, 1);
                chk("nom_lock_err", bus.lock_err, 0);
                chk("nom_retry", bus.retry_cnt, 0);

      // One-cycle lock drop in RUN: two synchronizer edges, then the registered reaction.
      bus.pll_lock = 1'b0;
      tick(1);
      bus.pll_lock = 1'b1;
      tick(1);  chk("drop_ddr_hold", bus.ddr_rst_n, 1);
      tick(1);  chk("drop_ddr", bus.ddr_rst_n, 0);
                chk("drop_en0", bus.pll_enclk0, 0);
                chk("drop_en2", bus.pll_enclk2, 0);
                chk("drop_ready", bus.init_ready, 0);
                chk("drop_lock_err", bus.lock_err, 1);
                chk("drop_retry", bus.retry_cnt, 1);
                chk("drop_pll_reset", bus.pll_reset, 1);
      tick(3);  chk("drop_pr_hold", bus.pll_reset, 1);
      tick(1);  chk("drop_pr_end", bus.pll_reset, 0);
      wait_lvl(1, 1'b1, 40, n);
      chk("drop_rerun_lat", n, 14);

      // err_clr alone clears; err_clr coincident with a lock drop loses to the set.
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      chk("clr_lock_err", bus.lock_err, 0);
      bus.pll_lock = 1'b0;
      tick(1);
      bus.pll_lock = 1'b1;
      tick(1);
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      chk("clr_vs_set_err", bus.lock_err, 1);
      chk("clr_vs_set_retry", bus.retry_cnt, 2);
      chk("clr_vs_set_ddr", bus.ddr_rst_n, 0);

      // soft_rst in RELEASE, then soft_rst inside RST restarting the count.
      tick(14); chk("soft_in_release", bus.pll_enclk0, 1);
                chk("soft_ddr_pre", bus.ddr_rst_n, 0);
      tick(1);
      bus.soft_rst = 1'b1;
      tick(1);
      bus.soft_rst = 1'b0;
      chk("soft_pll_reset", bus.pll_reset, 1);
      chk("soft_en2", bus.pll_enclk2, 0);
      chk("soft_retry", bus.retry_cnt, 2);
      chk("soft_lock_err", bus.lock_err, 1);
      tick(2);
      bus.soft_rst = 1'b1;
      tick(1);
      bus.soft_rst = 1'b0;
      tick(3);  chk("soft_restart_hold", bus.pll_reset, 1);
      tick(1);  chk("soft_restart_end", bus.pll_reset, 0);
      wait_lvl(1, 1'b1, 40, n);
      chk("soft_rerun_lat", n, 14);

      // Asynchronous reset mid-RUN, checked between clock edges.
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      tick(2);

      // Chattering lock (5 high, 1 low) never qualifies; timeout fires after 50 cycles.
      rst_n    = 1'b1;
      seen_en2 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         bus.pll_lock = ((i % 6) != 5);
         tick(1);
         if (bus.pll_enclk2 === 1'b1) seen_en2 = 1'b1;
         if (i == 54) chk("chat_retry_pre", bus.retry_cnt, 0);
         if (i == 55) begin
            chk("chat_retry_tmo", bus.retry_cnt, 1);
            chk("chat_pr_tmo", bus.pll_reset, 1);
         end
      end
      chk("chat_no_en2", seen_en2, 0);
      chk("chat_lock_err", bus.lock_err, 1);
      chk("chat_back_wait", bus.pll_reset, 0);
      bus.pll_lock = 1'b1;
      tick(9);  chk("chat_en2_early", bus.pll_enclk2, 0);
      tick(1);  chk("chat_en2", bus.pll_enclk2, 1);

      // Lock never asserts: 4-cycle pulses every 54 cycles, retry saturates at 15.
      rst_n        = 1'b0;
      bus.pll_lock = 1'b0;
      tick(2);
      rst_n = 1'b1;
      wait_lvl(0, 1'b0, 20, n);
      chk("nolock_first_rst", n, 6);
      wait_lvl(0, 1'b1, 80, n);
      chk("nolock_wait_width", n, 50);
      chk("nolock_retry1", bus.retry_cnt, 1);
      wait_lvl(0, 1'b0, 20, n);
      chk("nolock_pulse_width", n, 4);
      wait_lvl(2, 1'b1, 1000, n);
      chk("nolock_sat_lat", n, 752);
      tick(200);
      chk("nolock_sat_hold", bus.retry_cnt, 15);
      chk("nolock_lock_err", bus.lock_err, 1);

      chk("en_order", order_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
